exe_div: RTL and testbench

Iterative RV32M divide unit in the execute stage, fed directly by the ID/EX pipeline register with the same `op1`/`op2`/`inst`/`reg_waddr` bundle the ALU receives. It executes DIV, DIVU, REM and REMU with a radix-2 restoring algorithm. While busy, it holds the pipeline through a stall request to the stall controller. It returns one write-back result per instruction.

---
 rtl/exe_div_pkg.sv | 17 +
 rtl/exe_div.sv | 130 +++++++++++++
 tb/tb_exe_div.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/exe_div_pkg.sv
// exe_div_pkg: RV32M divide decode constants and divider FSM state encoding
package exe_div_pkg;

  localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [2:0] INST_DIV      = 3'b100;
  localparam logic [2:0] INST_DIVU     = 3'b101;
  localparam logic [2:0] INST_REM      = 3'b110;
  localparam logic [2:0] INST_REMU     = 3'b111;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_DONE
  } div_state_e;

endpackage

// File: rtl/exe_div.sv
// exe_div: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU; DIV_EARLY_OUT_EN skips CALC for div-by-zero and signed overflow
module exe_div
  import exe_div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [31:0]     inst_i,
  input  logic [4:0]      reg_waddr_i,
  input  logic            valid_i,
  input  logic            flush_i,
  output logic            stall_req_o,
  output logic [XLEN-1:0] result_o,
  output logic            result_valid_o,
  output logic            reg_we_o,
  output logic [4:0]      reg_waddr_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  div_state_e      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] dvd, dsr, rem, spec_res;
  logic            q_neg, r_neg, op_rem, special, done;
  logic [4:0]      waddr;

  logic [2:0]  funct3;
  logic        is_div, is_signed, is_rem, start, div_zero, ovf, sp;
  logic [XLEN-1:0] sp_res, q_fix, r_fix, res_n, rem_n, dvd_n;
  logic [XLEN:0]   shifted, diff;
  logic            ge;
  logic            unused_inst;

  assign funct3      = inst_i[14:12];
  assign unused_inst = ^{inst_i[24:15], inst_i[11:7]};
  assign is_div      = inst_i[6:0] == INST_TYPE_R_M && inst_i[31:25] == FUNCT7_MULDIV && funct3[2];
  assign is_signed   = funct3 == INST_DIV || funct3 == INST_REM;
  assign is_rem      = funct3 == INST_REM || funct3 == INST_REMU;
  // Reset gating keeps the stall request low while the unit is held in reset.
  assign start       = valid_i && is_div && !flush_i && state == DIV_IDLE && !rst_i;
  assign stall_req_o = start || state == DIV_CALC;

  // Special-case results are fully known at start and override the iteration.
  assign div_zero = op2_i == '0;
  assign ovf      = is_signed && op1_i == MIN_NEG && op2_i == '1;
  assign sp       = div_zero || ovf;
  assign sp_res   = div_zero ? (is_rem ? op1_i : '1) : (is_rem ? '0 : MIN_NEG);

  // One restoring step: shift {rem, dvd} left and trial-subtract the divisor.
  assign shifted = {rem, dvd[XLEN-1]};
  assign diff    = shifted - {1'b0, dsr};
  assign ge      = !diff[XLEN];
  assign rem_n   = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign dvd_n   = {dvd[XLEN-2:0], ge};
  assign q_fix   = q_neg ? -dvd_n : dvd_n;
  assign r_fix   = r_neg ? -rem_n : rem_n;
  assign res_n   = special ? spec_res : (op_rem ? r_fix : q_fix);

  assign result_valid_o = done && !flush_i;
  assign reg_we_o       = done && !flush_i;

  // Divider FSM: latch operands on start, iterate XLEN cycles, register the result into DONE.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state       <= DIV_IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dsr         <= '0;
      rem         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      op_rem      <= 1'b0;
      special     <= 1'b0;
      spec_res    <= '0;
      waddr       <= '0;
      done        <= 1'b0;
      result_o    <= '0;
      reg_waddr_o <= '0;
    end else begin
      case (state)
        DIV_IDLE: if (start) begin
          dvd      <= is_signed && op1_i[XLEN-1] ? -op1_i : op1_i;
          dsr      <= is_signed && op2_i[XLEN-1] ? -op2_i : op2_i;
          q_neg    <= is_signed && (op1_i[XLEN-1] ^ op2_i[XLEN-1]);
          r_neg    <= is_signed && op1_i[XLEN-1];
          op_rem   <= is_rem;
          special  <= sp;
          spec_res <= sp_res;
          waddr    <= reg_waddr_i;
          rem      <= '0;
          cnt      <= '0;
          if (EARLY_OUT && sp) begin
            state       <= DIV_DONE;
            result_o    <= sp_res;
            reg_waddr_o <= reg_waddr_i;
            done        <= 1'b1;
          end else
            state <= DIV_CALC;
        end
        DIV_CALC: if (flush_i)
          state <= DIV_IDLE;
        else begin
          rem <= rem_n;
          dvd <= dvd_n;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XLEN-1)) begin
            state       <= DIV_DONE;
            result_o    <= res_n;
            reg_waddr_o <= waddr;
            done        <= 1'b1;
          end
        end
        DIV_DONE: begin
          state <= DIV_IDLE;
          done  <= 1'b0;
        end
        default: state <= DIV_IDLE;
      endcase
    end

endmodule

// File: tb/tb_exe_div.sv
// tb_exe_div: table-driven checks of exe_div results, latency and stall, plus flush and reset sequences
module tb_exe_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] op1 = '0, op2 = '0, inst = '0;
  logic [4:0]  waddr_in = '0;
  logic        valid = 1'b0, flush = 1'b0;
  logic        stall, res_valid, we;
  logic [31:0] result;
  logic [4:0]  waddr_out;

  int pass_cnt = 0;
  int total = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int SP_LAT = 1;
`else
  localparam int SP_LAT = 33;
`endif

  exe_div #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst), .op1_i(op1), .op2_i(op2), .inst_i(inst),
    .reg_waddr_i(waddr_in), .valid_i(valid), .flush_i(flush),
    .stall_req_o(stall), .result_o(result), .result_valid_o(res_valid),
    .reg_we_o(we), .reg_waddr_o(waddr_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wa;
    logic [31:0] exp;
    bit          sp;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa);
    inst     = {7'b0000001, 5'd2, 5'd1, f3, 5'd0, 7'b0110011};
    op1      = a;
    op2      = b;
    waddr_in = wa;
    valid    = 1'b1;
  endtask

  task automatic run(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] wa, input logic [31:0] exp, input int exp_lat);
    int lat, stl;
    bit got;
    @(negedge clk);
    drive(f3, a, b, wa);
    #1 stl = stall ? 1 : 0;
    @(posedge clk);
    #1 valid = 1'b0;
    got = 0;
    lat = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (res_valid) got = 1;
      if (stall) stl++;
    end
    chk({name, " done seen"}, 32'(got), 32'd1);
    chk({name, " result"}, result, exp);
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " stall cycles"}, stl, exp_lat);
    chk({name, " we"}, 32'(we), 32'd1);
    chk({name, " waddr"}, 32'(waddr_out), 32'(wa));
  endtask

  initial begin
    int nv;
    vecs[0]  = '{3'b101, 32'd100,        32'd7,          5'd1,  32'd14,         1'b0};
    vecs[1]  = '{3'b100, 32'hFFFFFF9C,   32'd7,          5'd2,  32'hFFFFFFF2,   1'b0};
    vecs[2]  = '{3'b110, 32'hFFFFFF9C,   32'd7,          5'd3,  32'hFFFFFFFE,   1'b0};
    vecs[3]  = '{3'b111, 32'hFFFFFF9C,   32'd7,          5'd4,  32'd2,          1'b0};
    vecs[4]  = '{3'b101, 32'hFFFFFF9C,   32'd7,          5'd5,  32'h24924916,   1'b0};
    vecs[5]  = '{3'b100, 32'd5,          32'd0,          5'd6,  32'hFFFFFFFF,   1'b1};
    vecs[6]  = '{3'b110, 32'd5,          32'd0,          5'd7,  32'd5,          1'b1};
    vecs[7]  = '{3'b101, 32'd5,          32'd0,          5'd8,  32'hFFFFFFFF,   1'b1};
    vecs[8]  = '{3'b111, 32'hFFFFFFFB,   32'd0,          5'd9,  32'hFFFFFFFB,   1'b1};
    vecs[9]  = '{3'b100, 32'h80000000,   32'hFFFFFFFF,   5'd10, 32'h80000000,   1'b1};
    vecs[10] = '{3'b110, 32'h80000000,   32'hFFFFFFFF,   5'd11, 32'd0,          1'b1};
    vecs[11] = '{3'b101, 32'h80000000,   32'hFFFFFFFF,   5'd12, 32'd0,          1'b0};
    vecs[12] = '{3'b111, 32'h80000000,   32'hFFFFFFFF,   5'd13, 32'h80000000,   1'b0};
    vecs[13] = '{3'b100, 32'd7,          32'hFFFFFFFE,   5'd14, 32'hFFFFFFFD,   1'b0};
    vecs[14] = '{3'b110, 32'd7,          32'hFFFFFFFE,   5'd15, 32'd1,          1'b0};
    vecs[15] = '{3'b110, 32'hFFFFFFF9,   32'd2,          5'd16, 32'hFFFFFFFF,   1'b0};
    vecs[16] = '{3'b100, 32'hFFFFFFF9,   32'hFFFFFFFE,   5'd17, 32'd3,          1'b0};
    vecs[17] = '{3'b101, 32'hFFFFFFFF,   32'd1,          5'd31, 32'hFFFFFFFF,   1'b0};

    repeat (2) @(negedge clk);
    chk("reset result", result, 32'd0);
    chk("reset valid", 32'(res_valid), 32'd0);
    chk("reset we", 32'(we), 32'd0);
    chk("reset waddr", 32'(waddr_out), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++)
      run($sformatf("v%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].wa, vecs[i].exp,
          vecs[i].sp ? SP_LAT : 33);

    // Non-divide instruction (MUL) and a flushed divide must not stall.
    @(negedge clk);
    drive(3'b000, 32'd3, 32'd4, 5'd1);
    #1 chk("mul no stall", 32'(stall), 32'd0);
    drive(3'b101, 32'd3, 32'd4, 5'd1);
    flush = 1'b1;
    #1 chk("flushed start no stall", 32'(stall), 32'd0);
    valid = 1'b0;
    flush = 1'b0;

    // Flush during CALC aborts with no write-back.
    @(negedge clk);
    drive(3'b101, 32'd100, 32'd7, 5'd20);
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1 chk("flush calc stall before", 32'(stall), 32'd1);
    @(negedge clk);
    flush = 1'b0;
    #1 chk("flush calc stall after", 32'(stall), 32'd0);
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      if (res_valid || we) nv++;
    end
    chk("flush calc no valid", nv, 0);

    // Flush in DONE suppresses the strobe and the write.
    @(negedge clk);
    drive(3'b101, 32'd100, 32'd7, 5'd21);
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (33) @(negedge clk);
    flush = 1'b1;
    #1 chk("flush done valid", 32'(res_valid), 32'd0);
    chk("flush done we", 32'(we), 32'd0);
    chk("flush done result reg", result, 32'd14);
    @(negedge clk);
    flush = 1'b0;

    // Asynchronous reset mid-CALC with the instruction still held on the inputs.
    @(negedge clk);
    drive(3'b101, 32'd100, 32'd7, 5'd22);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async rst result", result, 32'd0);
    chk("async rst valid", 32'(res_valid), 32'd0);
    chk("async rst we", 32'(we), 32'd0);
    chk("async rst waddr", 32'(waddr_out), 32'd0);
    chk("async rst stall", 32'(stall), 32'd0);
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run("after rst 9/3", 3'b101, 32'd9, 32'd3, 5'd23, 32'd3, 33);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
